// File: rtl/id_ctrl_seq_if.sv
// ID-stage control decoder bundle: instruction inputs from ID and the
// registered control bus handed to the ID/EX boundary.
interface id_ctrl_seq_if #(
   parameter int NB_OP    = 6,
   parameter int NB_FUNCT = 6
);
   logic                i_valid;
   logic                i_stall;
   logic                i_flush;
   logic                i_bus_a_is_zero;
   logic [NB_OP-1:0]    i_op;
   logic [NB_FUNCT-1:0] i_funct;
   logic [16:0]         o_ctrl_regs;
   logic                o_valid;
   logic                o_draining;
   logic                o_halted;
   logic                o_illegal;

   modport master (
      output i_valid, i_stall, i_flush, i_bus_a_is_zero, i_op, i_funct,
      input  o_ctrl_regs, o_valid, o_draining, o_halted, o_illegal
   );

   modport slave (
      input  i_valid, i_stall, i_flush, i_bus_a_is_zero, i_op, i_funct,
      output o_ctrl_regs, o_valid, o_draining, o_halted, o_illegal
   );
endinterface

// File: rtl/id_ctrl_seq.sv
// Registered ID-stage control decoder with HALT drain FSM and illegal detect.
// Optional macro ID_CTRL_ILLEGAL_TRAP_EN: illegal instructions halt the core.
module id_ctrl_seq #(
   parameter int               NB_OP        = 6,
   parameter int               NB_FUNCT     = 6,
   parameter int               DRAIN_CYCLES = 4,
   parameter logic [NB_OP-1:0] HALT_OP      = {NB_OP{1'b1}}
) (
   input  logic          i_clk,
   input  logic          i_reset,
   id_ctrl_seq_if.slave  bus
);
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam logic [NB_OP-1:0] OP_RTYPE = 6'b000000;
   localparam logic [NB_OP-1:0] OP_J     = 6'b000010;
   localparam logic [NB_OP-1:0] OP_JAL   = 6'b000011;
   localparam logic [NB_OP-1:0] OP_BEQ   = 6'b000100;
   localparam logic [NB_OP-1:0] OP_BNE   = 6'b000101;
   localparam logic [NB_OP-1:0] OP_ADDI  = 6'b001000;
   localparam logic [NB_OP-1:0] OP_SLTI  = 6'b001010;
   localparam logic [NB_OP-1:0] OP_ANDI  = 6'b001100;
   localparam logic [NB_OP-1:0] OP_ORI   = 6'b001101;
   localparam logic [NB_OP-1:0] OP_XORI  = 6'b001110;
   localparam logic [NB_OP-1:0] OP_LUI   = 6'b001111;
   localparam logic [NB_OP-1:0] OP_LB    = 6'b100000;
   localparam logic [NB_OP-1:0] OP_LH    = 6'b100001;
   localparam logic [NB_OP-1:0] OP_LW    = 6'b100011;
   localparam logic [NB_OP-1:0] OP_LBU   = 6'b100100;
   localparam logic [NB_OP-1:0] OP_LHU   = 6'b100101;
   localparam logic [NB_OP-1:0] OP_LWU   = 6'b100111;
   localparam logic [NB_OP-1:0] OP_SB    = 6'b101000;
   localparam logic [NB_OP-1:0] OP_SH    = 6'b101001;
   localparam logic [NB_OP-1:0] OP_SW    = 6'b101011;

   localparam logic [NB_FUNCT-1:0] FN_JR   = 6'b001000;
   localparam logic [NB_FUNCT-1:0] FN_JALR = 6'b001001;

   typedef struct packed {
      logic       next_pc;
      logic [1:0] jmp;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       mem_write;
      logic       mem_unsigned;
      logic [1:0] mem_size;
      logic [1:0] alu_src;
      logic [2:0] alu_op;
   } ctrl_t;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg, cnt_next;
   ctrl_t      ctrl_reg, ctrl_next;
   logic       valid_reg, valid_next;
   logic       illegal_reg, illegal_next;

   ctrl_t      dec_ctrl;
   logic       dec_legal;
   logic       dec_halt;

   always_comb begin
      dec_ctrl  = '0;
      dec_legal = 1'b1;
      dec_halt  = 1'b0;
      case (bus.i_op)
         OP_RTYPE: begin
            case (bus.i_funct)
               FN_JR: begin
                  dec_ctrl.next_pc = 1'b1;
                  dec_ctrl.jmp     = 2'b01;
               end
               FN_JALR: begin
                  dec_ctrl.next_pc   = 1'b1;
                  dec_ctrl.jmp       = 2'b01;
                  dec_ctrl.reg_write = 1'b1;
                  dec_ctrl.reg_dst   = 2'b01;
               end
               6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
               6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b000000,
               6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111: begin
                  dec_ctrl.reg_write = 1'b1;
                  dec_ctrl.reg_dst   = 2'b01;
                  dec_ctrl.alu_op    = 3'b110;
               end
               default: dec_legal = 1'b0;
            endcase
         end
         OP_J, OP_JAL: begin
            dec_ctrl.next_pc   = 1'b1;
            dec_ctrl.jmp       = 2'b10;
            dec_ctrl.reg_write = (bus.i_op == OP_JAL);
            dec_ctrl.reg_dst   = (bus.i_op == OP_JAL) ? 2'b10 : 2'b00;
         end
         OP_BEQ, OP_BNE: begin
            // jmp stays 00 (branch target); only the taken decision differs
            dec_ctrl.next_pc = (bus.i_op == OP_BEQ) ? bus.i_bus_a_is_zero : ~bus.i_bus_a_is_zero;
            dec_ctrl.alu_op  = 3'b001;
         end
         OP_ADDI, OP_SLTI: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_src   = 2'b01;
            dec_ctrl.alu_op    = (bus.i_op == OP_SLTI) ? 3'b101 : 3'b000;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_src   = 2'b10;
            dec_ctrl.alu_op    = (bus.i_op == OP_ANDI) ? 3'b010 :
                                 (bus.i_op == OP_ORI)  ? 3'b011 : 3'b100;
         end
         OP_LUI: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_src   = 2'b11;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
            dec_ctrl.reg_write    = 1'b1;
            dec_ctrl.alu_src      = 2'b01;
            dec_ctrl.mem_unsigned = bus.i_op[2];
            dec_ctrl.mem_size     = (bus.i_op[1:0] == 2'b00) ? 2'b00 :
                                    (bus.i_op[1:0] == 2'b01) ? 2'b01 : 2'b10;
            dec_ctrl.mem_to_reg   = (bus.i_op[1:0] == 2'b00) ? 2'b11 :
                                    (bus.i_op[1:0] == 2'b01) ? 2'b10 : 2'b01;
         end
         OP_SB, OP_SH, OP_SW: begin
            dec_ctrl.mem_write = 1'b1;
            dec_ctrl.alu_src   = 2'b01;
            dec_ctrl.mem_size  = (bus.i_op[1:0] == 2'b00) ? 2'b00 :
                                 (bus.i_op[1:0] == 2'b01) ? 2'b01 : 2'b10;
         end
         HALT_OP: dec_halt = 1'b1;
         default: dec_legal = 1'b0;
      endcase
      if (!dec_legal) begin
         dec_ctrl = '0;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      ctrl_next    = ctrl_reg;
      valid_next   = valid_reg;
      illegal_next = illegal_reg;
      case (state_reg)
         RUN: begin
            if (bus.i_flush || !bus.i_stall) begin
               ctrl_next    = '0;
               valid_next   = 1'b0;
               illegal_next = TRAP ? illegal_reg : 1'b0;
            end
            if (!bus.i_flush && !bus.i_stall && bus.i_valid) begin
               if (dec_halt || (TRAP && !dec_legal)) begin
                  state_next = DRAIN;
                  cnt_next   = 4'(DRAIN_CYCLES - 1);
               end
               if (!dec_legal) begin
                  illegal_next = 1'b1;
               end else if (!dec_halt) begin
                  ctrl_next  = dec_ctrl;
                  valid_next = 1'b1;
               end
            end
         end
         DRAIN: begin
            // outputs are already a bubble here; flush has nothing to cancel
            if (!bus.i_stall) begin
               if (cnt_reg == 4'd0) begin
                  state_next = HALTED;
               end else begin
                  cnt_next = cnt_reg - 4'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg   <= RUN;
         cnt_reg     <= '0;
         ctrl_reg    <= '0;
         valid_reg   <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         ctrl_reg    <= ctrl_next;
         valid_reg   <= valid_next;
         illegal_reg <= illegal_next;
      end
   end

   assign bus.o_ctrl_regs = ctrl_reg;
   assign bus.o_valid     = valid_reg;
   assign bus.o_illegal   = illegal_reg;
   assign bus.o_draining  = (state_reg == DRAIN);
   assign bus.o_halted    = (state_reg == HALTED);
endmodule

// File: tb/tb_id_ctrl_seq.sv
// Directed + random bench for id_ctrl_seq against a table-driven reference.
module tb_id_ctrl_seq;
   localparam int DC = 4;
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_ctrl_seq_if #(.NB_OP(6), .NB_FUNCT(6)) bus ();

   id_ctrl_seq #(.NB_OP(6), .NB_FUNCT(6), .DRAIN_CYCLES(DC), .HALT_OP(6'h3f)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int step_no     = 0;

   logic [16:0] m_ctrl;
   logic        m_valid;
   logic        m_illegal;
   int          m_mode;   // 0 run, 1 drain, 2 halted
   int          m_left;

   logic [5:0] legal_ops [0:19] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                                    6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23,
                                    6'h24, 6'h25, 6'h27, 6'h28, 6'h29, 6'h2B};
   logic [5:0] r_functs [0:16] = '{6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                   6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03,
                                   6'h04, 6'h06, 6'h07};
   logic [5:0] bad_ops  [0:3]  = '{6'h13, 6'h01, 6'h3E, 6'h09};

   // Returns {legal, expected control word} straight from the encoding table.
   function automatic logic [17:0] ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                              input logic z);
      case (op)
         6'h00: case (fn)
            6'h08: return {1'b1, 17'h14000};
            6'h09: return {1'b1, 17'h16800};
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: return {1'b1, 17'h02806};
            default: return {1'b0, 17'h0};
         endcase
         6'h02: return {1'b1, 17'h18000};
         6'h03: return {1'b1, 17'h1B000};
         6'h04: return {1'b1, z ? 17'h10001 : 17'h00001};
         6'h05: return {1'b1, z ? 17'h00001 : 17'h10001};
         6'h08: return {1'b1, 17'h02008};
         6'h0A: return {1'b1, 17'h0200D};
         6'h0C: return {1'b1, 17'h02012};
         6'h0D: return {1'b1, 17'h02013};
         6'h0E: return {1'b1, 17'h02014};
         6'h0F: return {1'b1, 17'h02018};
         6'h20: return {1'b1, 17'h02608};
         6'h21: return {1'b1, 17'h02428};
         6'h23: return {1'b1, 17'h02248};
         6'h24: return {1'b1, 17'h02688};
         6'h25: return {1'b1, 17'h024A8};
         6'h27: return {1'b1, 17'h022C8};
         6'h28: return {1'b1, 17'h00108};
         6'h29: return {1'b1, 17'h00128};
         6'h2B: return {1'b1, 17'h00148};
         default: return {1'b0, 17'h0};
      endcase
   endfunction

   task automatic model_reset();
      m_ctrl = '0; m_valid = 0; m_illegal = 0; m_mode = 0; m_left = 0;
   endtask

   task automatic model_step(input logic v, input logic s, input logic f, input logic z,
                             input logic [5:0] op, input logic [5:0] fn);
      logic [17:0] r;
      r = ref_decode(op, fn, z);
      if (m_mode == 0) begin
         if (f || !s) begin
            m_ctrl = '0; m_valid = 0;
            if (!TRAP) m_illegal = 0;
         end
         if (!f && !s && v) begin
            if (op == 6'h3f) begin
               m_mode = 1; m_left = DC - 1;
            end else if (!r[17]) begin
               m_illegal = 1;
               if (TRAP) begin m_mode = 1; m_left = DC - 1; end
            end else begin
               m_ctrl = r[16:0]; m_valid = 1;
            end
         end
      end else if (m_mode == 1 && !s) begin
         if (m_left == 0) m_mode = 2;
         else m_left--;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("ctrl",     {15'b0, bus.o_ctrl_regs}, {15'b0, m_ctrl});
      chk("valid",    {31'b0, bus.o_valid},     {31'b0, m_valid});
      chk("illegal",  {31'b0, bus.o_illegal},   {31'b0, m_illegal});
      chk("draining", {31'b0, bus.o_draining},  (m_mode == 1) ? 32'd1 : 32'd0);
      chk("halted",   {31'b0, bus.o_halted},    (m_mode == 2) ? 32'd1 : 32'd0);
   endtask

   task automatic step(input logic v, input logic s, input logic f, input logic z,
                       input logic [5:0] op, input logic [5:0] fn);
      @(negedge clk);
      bus.i_valid = v; bus.i_stall = s; bus.i_flush = f;
      bus.i_bus_a_is_zero = z; bus.i_op = op; bus.i_funct = fn;
      @(posedge clk);
      #1;
      step_no++;
      model_step(v, s, f, z, op, fn);
      chk_all();
      $display("step %0d v=%0b s=%0b f=%0b z=%0b op=%h fn=%h -> ctrl=%h valid=%0b ill=%0b drn=%0b hlt=%0b",
               step_no, v, s, f, z, op, fn, bus.o_ctrl_regs, bus.o_valid, bus.o_illegal,
               bus.o_draining, bus.o_halted);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk_all();
      $display("async reset -> ctrl=%h valid=%0b drn=%0b hlt=%0b",
               bus.o_ctrl_regs, bus.o_valid, bus.o_draining, bus.o_halted);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [5:0] op, fn;
      int drain_seen;
      bus.i_valid = 0; bus.i_stall = 0; bus.i_flush = 0;
      bus.i_bus_a_is_zero = 0; bus.i_op = 0; bus.i_funct = 0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all();
      @(negedge clk);
      rst = 1'b0;

      step(1, 0, 0, 0, 6'h0C, 0);
      step(1, 0, 0, 0, 6'h20, 0);
      async_reset();
      step(1, 0, 0, 0, 6'h08, 0);
      chk("addi_word", {15'b0, bus.o_ctrl_regs}, 32'h02008);
      step(1, 0, 0, 0, 6'h24, 0);
      step(1, 0, 0, 1, 6'h04, 0);
      step(1, 0, 0, 0, 6'h04, 0);
      step(1, 0, 0, 0, 6'h00, 6'h08);
      step(1, 0, 0, 0, 6'h00, 6'h09);
      step(1, 0, 0, 0, 6'h03, 0);
      step(0, 0, 0, 0, 6'h08, 0);

      step(1, 0, 0, 0, 6'h08, 0);
      repeat (3) step(1, 1, 0, 0, 6'h23, 0);
      step(1, 0, 0, 0, 6'h23, 0);
      step(1, 1, 1, 0, 6'h08, 0);

      for (int i = 0; i < 200; i++) begin
         op = legal_ops[$urandom_range(0, 19)];
         fn = (op == 6'h00) ? r_functs[$urandom_range(0, 16)] : 6'($urandom);
         if (!TRAP && $urandom_range(0, 9) == 0) begin
            op = bad_ops[$urandom_range(0, 3)];
            if (op == 6'h09) begin op = 6'h00; fn = 6'h05; end
         end
         step($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) == 0, 1'($urandom), op, fn);
      end

      step(1, 0, 0, 0, 6'h13, 0);
      repeat (6) step(1, 0, 0, 0, 6'h08, 0);
      async_reset();

      step(1, 0, 0, 0, 6'h3f, 0);
      step(1, 0, 0, 0, 6'h08, 0);
      async_reset();
      step(1, 0, 0, 0, 6'h08, 0);
      step(1, 1, 1, 0, 6'h3f, 0);

      drain_seen = 0;
      step(1, 0, 0, 0, 6'h3f, 0); drain_seen += int'(bus.o_draining);
      step(1, 0, 1, 0, 6'h08, 0); drain_seen += int'(bus.o_draining);
      step(1, 1, 0, 0, 6'h08, 0); drain_seen += int'(bus.o_draining);
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0, 0, 6'h08, 0);
         drain_seen += int'(bus.o_draining);
      end
      chk("drain_len", drain_seen, 32'd5);
      chk("halted_sticky", {31'b0, bus.o_halted}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
